rv32_lsu_bus: RTL and testbench

- Load/store bus stage directly downstream of the MMU.
- Takes a translated physical address plus a RISC-V load/store descriptor and issues one word-aligned bus transaction with byte selects and lane-replicated store data.
- Returns sign- or zero-extended load data, or an error, with a valid/ready request handshake and a one-cycle response pulse.
- Misaligned accesses, illegal size codes, bus errors and bus timeouts all produce an error response.

---
 rtl/rv32_lsu_bus_if.sv | 39 +++
 rtl/rv32_lsu_bus.sv | 171 +++++++++++++++++
 tb/tb_rv32_lsu_bus.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_lsu_bus_if.sv
// Request/response handshake and bus signals of the load/store bus stage.
// The master modport is the LSU stage itself. It masters the memory bus and
// answers requests from the MMU side. The slave modport is the environment:
// the requester plus the bus target.
interface rv32_lsu_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        bus_cyc;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    input  req_valid, req_addr, req_we, req_funct3, req_wdata,
    input  bus_rdata, bus_ack, bus_err,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_cyc, bus_we, bus_addr, bus_sel, bus_wdata
  );

  modport slave (
    output req_valid, req_addr, req_we, req_funct3, req_wdata,
    output bus_rdata, bus_ack, bus_err,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_cyc, bus_we, bus_addr, bus_sel, bus_wdata
  );
endinterface

// File: rtl/rv32_lsu_bus.sv
// RV32 load/store bus stage. It accepts one translated request at a time and
// issues a single word-aligned bus cycle with byte selects and replicated
// store data. It then returns extended load data, or an error, as a one-cycle
// response pulse. Misaligned or illegal requests never reach the bus.
module rv32_lsu_bus #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input logic           clk,
  input logic           rst,
  rv32_lsu_bus_if.master lsu
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  // Last counter value before the timeout fires. A TIMEOUT_CYCLES of 0
  // disables the timeout entirely.
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST  =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t             state;
  logic               ready;
  logic               rvalid;
  logic [31:0]        rdata;
  logic               rerr;
  logic               cyc;
  logic               we;
  logic [31:0]        addr;
  logic [3:0]         sel;
  logic [31:0]        wdata;
  logic [CNT_W-1:0]   cnt;

  // Request fields needed after the accept edge to align and extend load data.
  logic [1:0]         off_p0;
  logic [2:0]         funct3_p0;

  // Size/sign code and alignment check. Stores have no unsigned variants.
  function automatic logic req_legal(input logic st, input logic [2:0] f3,
                                     input logic [1:0] off);
    case (f3)
      3'b000:  return 1'b1;
      3'b100:  return !st;
      3'b001:  return !off[0];
      3'b101:  return !st && !off[0];
      3'b010:  return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] size,
                                          input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size,
                                            input logic [31:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] extend_load(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] d);
    logic [31:0]        shifted;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    shifted = d >> {off, 3'b000};
    sb      = shifted[7:0];
    sh      = shifted[15:0];
    case (f3)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(sh);
      3'b100:  return {24'h0, shifted[7:0]};
      3'b101:  return {16'h0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  // Capture the request fields used for load alignment at the accept edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && lsu.req_valid) begin
      off_p0    <= lsu.req_addr[1:0];
      funct3_p0 <= lsu.req_funct3;
    end
  end

  // Control FSM. All handshake and bus outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ready  <= 1'b1;
      rvalid <= 1'b0;
      rdata  <= '0;
      rerr   <= 1'b0;
      cyc    <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      sel    <= '0;
      wdata  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu.req_valid) begin
            ready <= 1'b0;
            if (req_legal(lsu.req_we, lsu.req_funct3, lsu.req_addr[1:0])) begin
              state <= BUS;
              cyc   <= 1'b1;
              we    <= lsu.req_we;
              addr  <= {lsu.req_addr[31:2], 2'b00};
              sel   <= lane_sel(lsu.req_funct3[1:0], lsu.req_addr[1:0]);
              wdata <= lane_data(lsu.req_funct3[1:0], lsu.req_wdata);
              cnt   <= '0;
            end else begin
              state  <= RESP;
              rvalid <= 1'b1;
              rerr   <= 1'b1;
              rdata  <= '0;
            end
          end
        end
        BUS: begin
          if (lsu.bus_err || lsu.bus_ack ||
              (TIMEOUT_EN && cnt == CNT_LAST)) begin
            state  <= RESP;
            cyc    <= 1'b0;
            we     <= 1'b0;
            sel    <= '0;
            rvalid <= 1'b1;
            // Error wins over ack; ack wins over a timeout in the same cycle.
            rerr   <= lsu.bus_err || !lsu.bus_ack;
            if (!lsu.bus_err && lsu.bus_ack && !we)
              rdata <= extend_load(funct3_p0, off_p0, lsu.bus_rdata);
            else
              rdata <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state  <= IDLE;
          ready  <= 1'b1;
          rvalid <= 1'b0;
          rerr   <= 1'b0;
          rdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lsu.req_ready  = ready;
  assign lsu.resp_valid = rvalid;
  assign lsu.resp_rdata = rdata;
  assign lsu.resp_err   = rerr;
  assign lsu.bus_cyc    = cyc;
  assign lsu.bus_we     = we;
  assign lsu.bus_addr   = addr;
  assign lsu.bus_sel    = sel;
  assign lsu.bus_wdata  = wdata;

endmodule

// File: tb/tb_rv32_lsu_bus.sv
// Testbench for rv32_lsu_bus: directed vector table, randomized transactions
// against a byte-level reference model, and hand-written corner sequences.
module tb_rv32_lsu_bus;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32_lsu_bus_if ifc();

  rv32_lsu_bus #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .lsu(ifc)
  );

  int checks = 0;
  int errors = 0;

  // mode: 0 ack, 1 err, 2 ack+err, 3 never respond
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waitc;
    int          mode;
    logic        legal;
    logic [3:0]  sel;
    logic [31:0] bwd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model at byte granularity: size in bytes, lane ranges, and
  // arithmetic extension of the selected bytes.
  function automatic void model(input logic [31:0] addr, input logic we,
                                input logic [2:0] f3, input logic [31:0] wdata,
                                input logic [31:0] rdata, output logic legal,
                                output logic [3:0] sel, output logic [31:0] bwd,
                                output logic [31:0] rd);
    int size;
    int off;
    int sz;
    longint v;
    off = int'(addr % 4);
    case (f3[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      2'd2: size = 4;
      default: size = 0;
    endcase
    legal = (size != 0) && !(f3[2] && (size == 4 || we)) && (off % (size == 0 ? 1 : size) == 0);
    sz = (size == 0) ? 4 : size;
    sel = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + sz) sel[i] = 1'b1;
    for (int i = 0; i < 4; i++)
      bwd[8*i +: 8] = wdata[8*(i % sz) +: 8];
    v = longint'(rdata) >> (8 * off);
    v = v % (longint'(1) << (8 * sz));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    rd = we ? 32'h0 : v[31:0];
  endfunction

  // Issue one request, play the bus target, and check every cycle through
  // the return of req_ready.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                         input logic [2:0] f3, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waitc, input int mode,
                         input logic legal, input logic [3:0] sel,
                         input logic [31:0] bwd, input logic [31:0] rd,
                         input logic err);
    int n;
    chk({tag, " req_ready idle"}, ifc.req_ready, 1);
    ifc.req_valid  = 1'b1;
    ifc.req_addr   = addr;
    ifc.req_we     = we;
    ifc.req_funct3 = f3;
    ifc.req_wdata  = wdata;
    tick();
    ifc.req_valid = 1'b0;
    if (!legal) begin
      chk({tag, " bus_cyc"}, ifc.bus_cyc, 0);
      chk({tag, " resp_valid"}, ifc.resp_valid, 1);
      chk({tag, " resp_err"}, ifc.resp_err, 1);
      chk({tag, " resp_rdata"}, ifc.resp_rdata, 0);
      chk({tag, " req_ready busy"}, ifc.req_ready, 0);
      tick();
      chk({tag, " resp_valid drop"}, ifc.resp_valid, 0);
      chk({tag, " bus_cyc after"}, ifc.bus_cyc, 0);
      chk({tag, " req_ready back"}, ifc.req_ready, 1);
    end else begin
      n = (mode == 3 || waitc + 1 > TO) ? TO : waitc + 1;
      chk({tag, " bus_addr"}, ifc.bus_addr, {addr[31:2], 2'b00});
      if (we) chk({tag, " bus_wdata"}, ifc.bus_wdata, bwd);
      for (int i = 1; i <= n; i++) begin
        chk({tag, " bus_cyc"}, ifc.bus_cyc, 1);
        chk({tag, " bus_sel"}, {28'h0, ifc.bus_sel}, {28'h0, sel});
        chk({tag, " bus_we"}, ifc.bus_we, we);
        chk({tag, " resp_valid in bus"}, ifc.resp_valid, 0);
        if (i == waitc + 1 && mode != 3) begin
          ifc.bus_ack   = (mode == 0 || mode == 2);
          ifc.bus_err   = (mode == 1 || mode == 2);
          ifc.bus_rdata = rdata;
        end else begin
          ifc.bus_rdata = $urandom;
        end
        tick();
        ifc.bus_ack = 1'b0;
        ifc.bus_err = 1'b0;
      end
      chk({tag, " resp_valid"}, ifc.resp_valid, 1);
      chk({tag, " resp_err"}, ifc.resp_err, err);
      chk({tag, " resp_rdata"}, ifc.resp_rdata, err ? 32'h0 : rd);
      chk({tag, " bus_cyc drop"}, ifc.bus_cyc, 0);
      chk({tag, " bus_sel drop"}, {28'h0, ifc.bus_sel}, 0);
      chk({tag, " bus_we drop"}, ifc.bus_we, 0);
      chk({tag, " req_ready resp"}, ifc.req_ready, 0);
      tick();
      chk({tag, " resp_valid drop"}, ifc.resp_valid, 0);
      chk({tag, " resp_err drop"}, ifc.resp_err, 0);
      chk({tag, " resp_rdata drop"}, ifc.resp_rdata, 0);
      chk({tag, " req_ready back"}, ifc.req_ready, 1);
    end
  endtask

  initial begin
    logic        m_legal;
    logic [3:0]  m_sel;
    logic [31:0] m_bwd, m_rd;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        r_we, r_err;
    logic [2:0]  r_f3;
    int          r_wait, r_mode, r;

    tbl[0]  = '{32'h8000_0003, 1'b0, 3'b000, 32'h0, 32'h8100_0000, 0, 0, 1'b1, 4'b1000, 32'h0, 32'hFFFF_FF81, 1'b0};
    tbl[1]  = '{32'h0000_1002, 1'b0, 3'b101, 32'h0, 32'hBEEF_1234, 0, 0, 1'b1, 4'b1100, 32'h0, 32'h0000_BEEF, 1'b0};
    tbl[2]  = '{32'h0000_2001, 1'b1, 3'b000, 32'h1234_56AB, 32'hDEAD_BEEF, 3, 0, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0, 1'b0};
    tbl[3]  = '{32'h0000_2002, 1'b0, 3'b010, 32'h0, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[4]  = '{32'h0000_3000, 1'b0, 3'b110, 32'h0, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[5]  = '{32'h0000_4000, 1'b0, 3'b010, 32'h0, 32'h5555_AAAA, 1, 2, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1};
    tbl[6]  = '{32'h0000_5000, 1'b0, 3'b010, 32'h0, 32'h0000_0001, 0, 3, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1};
    tbl[7]  = '{32'h0000_5004, 1'b0, 3'b010, 32'h0, 32'hCAFE_BABE, 15, 0, 1'b1, 4'b1111, 32'h0, 32'hCAFE_BABE, 1'b0};
    tbl[8]  = '{32'h0000_5008, 1'b0, 3'b010, 32'h0, 32'h0000_0007, 16, 0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1};
    tbl[9]  = '{32'h0000_6002, 1'b1, 3'b001, 32'hFFFF_A5C3, 32'h0, 0, 0, 1'b1, 4'b1100, 32'hA5C3_A5C3, 32'h0, 1'b0};
    tbl[10] = '{32'h0000_7000, 1'b1, 3'b100, 32'h0000_0011, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};
    tbl[11] = '{32'h0000_0010, 1'b0, 3'b001, 32'h0, 32'h1234_8001, 0, 0, 1'b1, 4'b0011, 32'h0, 32'hFFFF_8001, 1'b0};
    tbl[12] = '{32'h0000_0012, 1'b0, 3'b100, 32'h0, 32'h00F0_0000, 2, 0, 1'b1, 4'b0100, 32'h0, 32'h0000_00F0, 1'b0};
    tbl[13] = '{32'h0000_9000, 1'b1, 3'b010, 32'h1122_3344, 32'h0, 2, 1, 1'b1, 4'b1111, 32'h1122_3344, 32'h0, 1'b1};
    tbl[14] = '{32'h0000_0003, 1'b0, 3'b001, 32'h0, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1};

    ifc.req_valid  = 1'b0;
    ifc.req_addr   = '0;
    ifc.req_we     = 1'b0;
    ifc.req_funct3 = '0;
    ifc.req_wdata  = '0;
    ifc.bus_rdata  = '0;
    ifc.bus_ack    = 1'b0;
    ifc.bus_err    = 1'b0;

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst req_ready", ifc.req_ready, 1);
    chk("rst resp_valid", ifc.resp_valid, 0);
    chk("rst resp_rdata", ifc.resp_rdata, 0);
    chk("rst resp_err", ifc.resp_err, 0);
    chk("rst bus_cyc", ifc.bus_cyc, 0);
    chk("rst bus_we", ifc.bus_we, 0);
    chk("rst bus_addr", ifc.bus_addr, 0);
    chk("rst bus_sel", {28'h0, ifc.bus_sel}, 0);
    chk("rst bus_wdata", ifc.bus_wdata, 0);
    rst = 1'b0;
    tick();

    // Bus completions while idle are ignored
    ifc.bus_ack = 1'b1;
    ifc.bus_err = 1'b1;
    tick();
    ifc.bus_ack = 1'b0;
    ifc.bus_err = 1'b0;
    chk("idle ack resp_valid", ifc.resp_valid, 0);
    chk("idle ack req_ready", ifc.req_ready, 1);

    // Directed vector table
    for (int i = 0; i < 15; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].we, tbl[i].f3, tbl[i].wdata,
              tbl[i].rdata, tbl[i].waitc, tbl[i].mode, tbl[i].legal, tbl[i].sel,
              tbl[i].bwd, tbl[i].rd, tbl[i].err);

    // Reset during BUS aborts the request without a response
    ifc.req_valid  = 1'b1;
    ifc.req_addr   = 32'h0000_0100;
    ifc.req_we     = 1'b0;
    ifc.req_funct3 = 3'b010;
    tick();
    ifc.req_valid = 1'b0;
    chk("abort bus_cyc", ifc.bus_cyc, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort bus_cyc drop", ifc.bus_cyc, 0);
    chk("abort resp_valid", ifc.resp_valid, 0);
    chk("abort req_ready", ifc.req_ready, 1);
    ifc.bus_ack = 1'b1;
    tick();
    ifc.bus_ack = 1'b0;
    chk("abort late resp_valid", ifc.resp_valid, 0);
    chk("abort late bus_cyc", ifc.bus_cyc, 0);

    // req_valid held through BUS and RESP issues only one transaction
    ifc.req_valid  = 1'b1;
    ifc.req_addr   = 32'h0000_0200;
    ifc.req_we     = 1'b0;
    ifc.req_funct3 = 3'b010;
    tick();
    ifc.req_addr = 32'h0000_0300;
    chk("busy bus_addr", ifc.bus_addr, 32'h0000_0200);
    tick();
    chk("busy bus_addr held", ifc.bus_addr, 32'h0000_0200);
    chk("busy bus_cyc", ifc.bus_cyc, 1);
    ifc.bus_ack   = 1'b1;
    ifc.bus_rdata = 32'h0BAD_F00D;
    tick();
    ifc.bus_ack = 1'b0;
    chk("busy resp_valid", ifc.resp_valid, 1);
    chk("busy resp_rdata", ifc.resp_rdata, 32'h0BAD_F00D);
    chk("busy req_ready", ifc.req_ready, 0);
    ifc.req_valid = 1'b0;
    tick();
    chk("busy req_ready back", ifc.req_ready, 1);
    chk("busy resp_valid drop", ifc.resp_valid, 0);
    tick();
    chk("busy no second cyc", ifc.bus_cyc, 0);
    chk("busy no second resp", ifc.resp_valid, 0);

    // Randomized transactions against the reference model
    for (int k = 0; k < 80; k++) begin
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_wait  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
      r       = $urandom_range(0, 9);
      r_mode  = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
      model(r_addr, r_we, r_f3, r_wdata, r_rdata, m_legal, m_sel, m_bwd, m_rd);
      if (!m_legal) r_err = 1'b1;
      else if (r_mode == 3 || r_wait + 1 > TO) r_err = 1'b1;
      else r_err = (r_mode != 0);
      run_txn($sformatf("rnd%0d", k), r_addr, r_we, r_f3, r_wdata, r_rdata, r_wait,
              r_mode, m_legal, m_sel, m_bwd, m_rd, r_err);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

endmodule
